input_acc_bank: RTL and testbench
=================================

// Module: input_acc_bank
// PURPOSE
//  Multi-lane input staging buffer feeding the systolic array's west edge. One circular FIFO per row lane.
//  Two write sources per lane: host load and NN feedback (previous-layer activations).
//  Reads are issued by one global read strobe and skewed per lane (lane i delayed i cycles) to form the
//  systolic diagonal. Optional replay: a marked window can be re-streamed for reuse across weight tiles.
// PARAMETERS
//  DATA_WIDTH  16  signed element width
//  DEPTH       8   entries per lane; power of 2, >=2
//  LANES       2   lanes (array rows)
//  REPLAY_EN   1   1: mark/rewind honoured; 0: mark_in/rewind_in ignored, entries freed on read
// PORTS
//  clk            in   1                   clock
//  rst            in   1                   async active-high reset
//  wr_valid_in    in   LANES               host write strobe per lane
//  wr_data_in     in   LANES*DATA_WIDTH    host write data per lane
//  wr_valid_nn_in in   LANES               NN-feedback write strobe per lane
//  wr_data_nn_in  in   LANES*DATA_WIDTH    NN-feedback write data per lane
//  rd_valid_in    in   1                   global read request (lane 0 timing)
//  mark_in        in   1                   set replay mark, all lanes
//  rewind_in      in   1                   return read pointers to mark, all lanes
//  flush_in       in   1                   synchronous clear
//  valid_out      out  LANES               registered read-data valid
//  data_out       out  LANES*DATA_WIDTH    registered read data
//  full_out       out  LANES               occupied == DEPTH
//  empty_out      out  LANES               readable == 0
//  drop_out       out  1                   sticky: a write was discarded
//  underflow_out  out  1                   sticky: a read hit an empty lane
// BEHAVIOUR
//  Reset (async): ptrs, counts, skew chain, valid_out, data_out, drop_out, underflow_out -> 0; empty_out=1.
//  Per lane: wr_ptr, rd_ptr, mark_ptr (PTR_W=$clog2(DEPTH), natural wrap).
//   occupied = wr_ptr-mark_ptr; readable = wr_ptr-rd_ptr; counts PTR_W+1 bits.
//  Write source select: nn has priority; if both strobes high, nn is written, host is dropped, drop_out set.
//   Accepted if occupied<DEPTH, or occupied==DEPTH and REPLAY_EN=0 and the lane reads this cycle.
//   Otherwise the write is dropped and drop_out is set.
//  Read skew: rd_valid_in enters a LANES-1 stage shift chain; lane i sees the request i cycles later.
//   Lane read fires if request && readable!=0. Then data_out[i] <= mem[rd_ptr], valid_out[i] <= 1, rd_ptr++.
//   Request with readable==0: valid_out[i] <= 0, data_out[i] holds, underflow_out set.
//   Latency: lane i data valid i+1 cycles after rd_valid_in.
//   Same-cycle write to an empty lane is not readable until the next cycle.
//  Replay (REPLAY_EN=1):
//   mark_in: mark_ptr <= rd_ptr after this cycle's read, which frees the consumed entries.
//   rewind_in: rd_ptr <= mark_ptr; skew chain cleared; this cycle's lane reads are suppressed (valid_out=0).
//   rewind_in and mark_in together: rewind wins, mark ignored.
//  REPLAY_EN=0: mark_ptr tracks rd_ptr every cycle (plain FIFO).
//  flush_in: ptrs, counts, skew chain, valid_out, drop_out, underflow_out -> 0; data_out holds.
//   Overrides all other inputs that cycle.
//  Reset mid-stream: all in-flight skewed reads are lost; no valid_out after reset deasserts without a new read.
// STRUCTURE
//  tpu_pkg: data_t (logic signed [DATA_WIDTH-1:0]), ptr helper function, DATA_WIDTH default const.
//  Sub-module input_acc_lane_fifo: one lane, with its write mux, pointers, mark, flags, and registered output.
//  Top: generate loop over LANES, shared skew shift register, OR-reduce of lane drop/underflow into sticky flags.
// TESTING
//  1. LANES=2,DEPTH=4: host writes 1,2,3 to both lanes; one rd_valid_in pulse.
//     -> lane0 out 1 at +1 cyc, lane1 out 1 at +2 cyc.
//  2. Same cycle, wr_valid_in=1 (data 5) and wr_valid_nn_in=1 (data 9) on lane0.
//     -> 9 stored, 5 dropped, drop_out=1.
//  3. Fill lane0 to 4 (REPLAY_EN=1), write 7.
//     -> dropped, full_out=1, drop_out=1; with REPLAY_EN=0 and a same-cycle read -> accepted, full stays.
//  4. Write 10,20,30; mark; read x3 (10,20,30); rewind; read x3.
//     -> 10,20,30 replayed; mark_in after the reads -> full_out=0, occupied=0.
//  5. Read an empty lane.
//     -> valid_out=0, data_out unchanged, underflow_out=1, sticky until flush_in.
//  6. rst asserted asynchronously mid-burst with lane1 read pending.
//     -> outputs 0 immediately, no late lane1 valid.

Source files
------------

// File: rtl/input_acc_bank_pkg.sv
// input_acc_bank_pkg: shared types and helpers for the systolic west-edge input staging bank
package input_acc_bank_pkg;
   localparam int DATA_WIDTH_DEF = 16;
   typedef logic signed [DATA_WIDTH_DEF-1:0] data_t;
   function automatic int ptr_w(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction
endpackage

// File: rtl/input_acc_lane_fifo.sv
// input_acc_lane_fifo: one circular lane FIFO with host/NN write mux, replay mark and registered read port
module input_acc_lane_fifo
   import input_acc_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 8,
   parameter int REPLAY_EN  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic                  wr_valid_nn,
   input  logic [DATA_WIDTH-1:0] wr_data_nn,
   input  logic                  rd_req,
   input  logic                  mark,
   input  logic                  rewind,
   input  logic                  flush,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  full,
   output logic                  empty,
   output logic                  drop,
   output logic                  underflow
);
   localparam int PW = ptr_w(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);
   localparam logic [PW:0] ONE = 1;
   // pointers carry one wrap bit so occupancy can reach DEPTH
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [PW:0] wr_ptr, rd_ptr, mark_ptr, occupied, readable, rd_next;
   logic rw, fire, any, accept;
   logic [DATA_WIDTH-1:0] wr_sel;
   always_comb begin
      rw        = (REPLAY_EN != 0) && rewind;
      occupied  = wr_ptr - mark_ptr;
      readable  = wr_ptr - rd_ptr;
      fire      = rd_req && (readable != 0) && !rw;
      any       = wr_valid || wr_valid_nn;
      accept    = any && ((occupied < FULL_CNT) || (REPLAY_EN == 0 && fire));
      wr_sel    = wr_valid_nn ? wr_data_nn : wr_data;
      rd_next   = fire ? rd_ptr + ONE : rd_ptr;
      full      = occupied == FULL_CNT;
      empty     = readable == 0;
      drop      = (wr_valid && wr_valid_nn) || (any && !accept);
      underflow = rd_req && !rw && (readable == 0);
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mark_ptr <= '0;
         valid    <= 1'b0;
         data     <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         mark_ptr <= '0;
         valid    <= 1'b0;
      end else begin
         valid <= fire;
         if (fire) data <= mem[rd_ptr[PW-1:0]];
         if (accept) wr_ptr <= wr_ptr + ONE;
         rd_ptr <= rw ? mark_ptr : rd_next;
         if (REPLAY_EN == 0 || (mark && !rw)) mark_ptr <= rd_next;
      end
   end
   always_ff @(posedge clk) begin
      if (accept && !flush) mem[wr_ptr[PW-1:0]] <= wr_sel;
   end
endmodule

// File: rtl/input_acc_bank.sv
// input_acc_bank: multi-lane input staging buffer; global read strobe skewed one cycle per lane
module input_acc_bank
   import input_acc_bank_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = 8,
   parameter int LANES      = 2,
   parameter int REPLAY_EN  = 1
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [LANES-1:0]            wr_valid_in,
   input  logic [LANES*DATA_WIDTH-1:0] wr_data_in,
   input  logic [LANES-1:0]            wr_valid_nn_in,
   input  logic [LANES*DATA_WIDTH-1:0] wr_data_nn_in,
   input  logic                        rd_valid_in,
   input  logic                        mark_in,
   input  logic                        rewind_in,
   input  logic                        flush_in,
   output logic [LANES-1:0]            valid_out,
   output logic [LANES*DATA_WIDTH-1:0] data_out,
   output logic [LANES-1:0]            full_out,
   output logic [LANES-1:0]            empty_out,
   output logic                        drop_out,
   output logic                        underflow_out
);
   logic [LANES-1:0] sk, req, lane_drop, lane_und;
   // req[i] is rd_valid_in delayed i cycles
   always_comb req = (sk << 1) | LANES'(rd_valid_in);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sk            <= '0;
         drop_out      <= 1'b0;
         underflow_out <= 1'b0;
      end else if (flush_in) begin
         sk            <= '0;
         drop_out      <= 1'b0;
         underflow_out <= 1'b0;
      end else begin
         sk            <= (REPLAY_EN != 0 && rewind_in) ? '0 : req;
         drop_out      <= drop_out | (|lane_drop);
         underflow_out <= underflow_out | (|lane_und);
      end
   end
   for (genvar i = 0; i < LANES; i++) begin : g_lane
      input_acc_lane_fifo #(
         .DATA_WIDTH(DATA_WIDTH),
         .DEPTH     (DEPTH),
         .REPLAY_EN (REPLAY_EN)
      ) u_lane (
         .clk        (clk),
         .rst        (rst),
         .wr_valid   (wr_valid_in[i]),
         .wr_data    (wr_data_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .wr_valid_nn(wr_valid_nn_in[i]),
         .wr_data_nn (wr_data_nn_in[i*DATA_WIDTH +: DATA_WIDTH]),
         .rd_req     (req[i]),
         .mark       (mark_in),
         .rewind     (rewind_in),
         .flush      (flush_in),
         .valid      (valid_out[i]),
         .data       (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
         .full       (full_out[i]),
         .empty      (empty_out[i]),
         .drop       (lane_drop[i]),
         .underflow  (lane_und[i])
      );
   end
endmodule

// File: tb/tb_input_acc_bank.sv
// tb_input_acc_bank: directed table, corner sequences and random traffic against a pointer-free queue model
module tb_input_acc_bank;
   localparam int DW = 16, DEPTH = 4;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;
   logic [1:0] wv = '0, nv = '0;
   logic [31:0] wd = '0, nd = '0;
   logic rd = 1'b0, mk = 1'b0, rw = 1'b0, fl = 1'b0;
   logic [1:0] va, vb, fa, fb, ea, eb;
   logic [31:0] da, db;
   logic dra, drb, ua, ub;
   input_acc_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LANES(2), .REPLAY_EN(1)) dut_a (
      .clk(clk), .rst(rst), .wr_valid_in(wv), .wr_data_in(wd), .wr_valid_nn_in(nv), .wr_data_nn_in(nd),
      .rd_valid_in(rd), .mark_in(mk), .rewind_in(rw), .flush_in(fl), .valid_out(va), .data_out(da),
      .full_out(fa), .empty_out(ea), .drop_out(dra), .underflow_out(ua));
   input_acc_bank #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .LANES(2), .REPLAY_EN(0)) dut_b (
      .clk(clk), .rst(rst), .wr_valid_in(wv), .wr_data_in(wd), .wr_valid_nn_in(nv), .wr_data_nn_in(nd),
      .rd_valid_in(rd), .mark_in(mk), .rewind_in(rw), .flush_in(fl), .valid_out(vb), .data_out(db),
      .full_out(fb), .empty_out(eb), .drop_out(drb), .underflow_out(ub));

   int nvec = 0, nerr = 0;
   // model: each lane is an ever-growing list indexed by absolute write/read/mark counts; index 0 = replay bank
   logic [15:0] hist [2][2][4096];
   int mwr [2][2], mrd [2][2], mmk [2][2];
   logic [1:0] ev [2];
   logic [15:0] ed [2][2];
   logic edrop [2], eund [2], esk [2];

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      nvec++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         ev[d] = '0; edrop[d] = 1'b0; eund[d] = 1'b0; esk[d] = 1'b0;
         for (int l = 0; l < 2; l++) begin
            mwr[d][l] = 0; mrd[d][l] = 0; mmk[d][l] = 0; ed[d][l] = '0;
         end
      end
   endtask

   task automatic model_step();
      for (int d = 0; d < 2; d++) begin
         bit rp, rwe, req, fire, any, acc;
         int rdbl, occ;
         rp = (d == 0);
         rwe = rp && rw;
         if (fl) begin
            for (int l = 0; l < 2; l++) begin
               mwr[d][l] = 0; mrd[d][l] = 0; mmk[d][l] = 0;
            end
            ev[d] = '0; edrop[d] = 1'b0; eund[d] = 1'b0; esk[d] = 1'b0;
         end else begin
            for (int l = 0; l < 2; l++) begin
               req = (l == 0) ? rd : esk[d];
               rdbl = mwr[d][l] - mrd[d][l];
               occ = mwr[d][l] - mmk[d][l];
               fire = req && rdbl > 0 && !rwe;
               ev[d][l] = fire;
               if (fire) ed[d][l] = hist[d][l][mrd[d][l] % 4096];
               if (req && !rwe && rdbl == 0) eund[d] = 1'b1;
               any = wv[l] || nv[l];
               acc = any && (occ < DEPTH || (!rp && fire));
               if ((wv[l] && nv[l]) || (any && !acc)) edrop[d] = 1'b1;
               if (acc) begin
                  hist[d][l][mwr[d][l] % 4096] = nv[l] ? nd[l*16 +: 16] : wd[l*16 +: 16];
                  mwr[d][l]++;
               end
               if (fire) mrd[d][l]++;
               if (!rp) mmk[d][l] = mrd[d][l];
               else if (rwe) mrd[d][l] = mmk[d][l];
               else if (mk) mmk[d][l] = mrd[d][l];
            end
            esk[d] = rd && !rwe;
         end
      end
   endtask

   task automatic cmp_all();
      for (int d = 0; d < 2; d++) begin
         logic [1:0] ef, ee;
         for (int l = 0; l < 2; l++) begin
            ef[l] = (mwr[d][l] - mmk[d][l]) == DEPTH;
            ee[l] = mwr[d][l] == mrd[d][l];
         end
         chk(d ? "valid_b" : "valid_a", d ? 32'(vb) : 32'(va), 32'(ev[d]));
         chk(d ? "data_b" : "data_a", d ? db : da, {ed[d][1], ed[d][0]});
         chk(d ? "full_b" : "full_a", d ? 32'(fb) : 32'(fa), 32'(ef));
         chk(d ? "empty_b" : "empty_a", d ? 32'(eb) : 32'(ea), 32'(ee));
         chk(d ? "drop_b" : "drop_a", d ? 32'(drb) : 32'(dra), 32'(edrop[d]));
         chk(d ? "under_b" : "under_a", d ? 32'(ub) : 32'(ua), 32'(eund[d]));
      end
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      cmp_all();
   endtask

   task automatic idle();
      wv = '0; nv = '0; rd = 1'b0; mk = 1'b0; rw = 1'b0; fl = 1'b0;
   endtask

   typedef struct {
      logic [1:0] wv; logic [15:0] hd; logic [1:0] nv; logic [15:0] ndv;
      logic rd, mk, rw, fl;
      logic [1:0] v; logic [15:0] d0, d1; logic [1:0] f, e; logic drop, und;
   } vec_t;
   vec_t tbl [31];

   function automatic vec_t mkv(int w, int h, int n, int ndv, int r, int m, int re, int f,
                                int v, int d0, int d1, int fu, int e, int dr, int u);
      vec_t t;
      t.wv = 2'(w); t.hd = 16'(h); t.nv = 2'(n); t.ndv = 16'(ndv);
      t.rd = 1'(r); t.mk = 1'(m); t.rw = 1'(re); t.fl = 1'(f);
      t.v = 2'(v); t.d0 = 16'(d0); t.d1 = 16'(d1); t.f = 2'(fu); t.e = 2'(e);
      t.drop = 1'(dr); t.und = 1'(u);
      return t;
   endfunction

   initial begin
      //             wv  hd nv nd rd mk rw fl   v  d0  d1  f  e dr u
      tbl[0]  = mkv(3,  1, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
      tbl[1]  = mkv(3,  2, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
      tbl[2]  = mkv(3,  3, 0, 0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0, 0);
      tbl[3]  = mkv(0,  0, 0, 0, 1, 0, 0, 0,  1,  1,  0, 0, 0, 0, 0);
      tbl[4]  = mkv(0,  0, 0, 0, 0, 0, 0, 0,  2,  1,  1, 0, 0, 0, 0);
      tbl[5]  = mkv(0,  0, 0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 0, 0, 0);
      tbl[6]  = mkv(1,  5, 1, 9, 0, 0, 0, 0,  0,  1,  1, 1, 0, 1, 0);
      tbl[7]  = mkv(0,  0, 0, 0, 0, 0, 0, 1,  0,  1,  1, 0, 3, 0, 0);
      tbl[8]  = mkv(1, 11, 0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 2, 0, 0);
      tbl[9]  = mkv(1, 12, 0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 2, 0, 0);
      tbl[10] = mkv(1, 13, 0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 2, 0, 0);
      tbl[11] = mkv(1, 14, 0, 0, 0, 0, 0, 0,  0,  1,  1, 1, 2, 0, 0);
      tbl[12] = mkv(1,  7, 0, 0, 0, 0, 0, 0,  0,  1,  1, 1, 2, 1, 0);
      tbl[13] = mkv(0,  0, 0, 0, 0, 0, 0, 1,  0,  1,  1, 0, 3, 0, 0);
      tbl[14] = mkv(3, 10, 0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 0, 0, 0);
      tbl[15] = mkv(3, 20, 0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 0, 0, 0);
      tbl[16] = mkv(3, 30, 0, 0, 0, 0, 0, 0,  0,  1,  1, 0, 0, 0, 0);
      tbl[17] = mkv(0,  0, 0, 0, 0, 1, 0, 0,  0,  1,  1, 0, 0, 0, 0);
      tbl[18] = mkv(0,  0, 0, 0, 1, 0, 0, 0,  1, 10,  1, 0, 0, 0, 0);
      tbl[19] = mkv(0,  0, 0, 0, 1, 0, 0, 0,  3, 20, 10, 0, 0, 0, 0);
      tbl[20] = mkv(0,  0, 0, 0, 1, 0, 0, 0,  3, 30, 20, 0, 1, 0, 0);
      tbl[21] = mkv(0,  0, 0, 0, 0, 0, 1, 0,  0, 30, 20, 0, 0, 0, 0);
      tbl[22] = mkv(0,  0, 0, 0, 1, 0, 0, 0,  1, 10, 20, 0, 0, 0, 0);
      tbl[23] = mkv(0,  0, 0, 0, 1, 0, 0, 0,  3, 20, 10, 0, 0, 0, 0);
      tbl[24] = mkv(0,  0, 0, 0, 1, 0, 0, 0,  3, 30, 20, 0, 1, 0, 0);
      tbl[25] = mkv(0,  0, 0, 0, 0, 1, 0, 0,  2, 30, 30, 0, 3, 0, 0);
      tbl[26] = mkv(0,  0, 0, 0, 0, 0, 0, 0,  0, 30, 30, 0, 3, 0, 0);
      tbl[27] = mkv(0,  0, 0, 0, 1, 0, 0, 0,  0, 30, 30, 0, 3, 0, 1);
      tbl[28] = mkv(0,  0, 0, 0, 0, 0, 0, 0,  0, 30, 30, 0, 3, 0, 1);
      tbl[29] = mkv(0,  0, 0, 0, 0, 0, 0, 0,  0, 30, 30, 0, 3, 0, 1);
      tbl[30] = mkv(0,  0, 0, 0, 0, 0, 0, 1,  0, 30, 30, 0, 3, 0, 0);

      // reset state
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(va), 0);
      chk("rst_data", da, 0);
      chk("rst_empty", 32'(ea), 3);
      chk("rst_full", 32'(fa), 0);
      chk("rst_flags", {30'd0, dra, ua}, 0);
      rst = 1'b0;

      // directed table on the replay bank
      for (int i = 0; i < 31; i++) begin
         wv = tbl[i].wv; wd = {tbl[i].hd, tbl[i].hd};
         nv = tbl[i].nv; nd = {tbl[i].ndv, tbl[i].ndv};
         rd = tbl[i].rd; mk = tbl[i].mk; rw = tbl[i].rw; fl = tbl[i].fl;
         step();
         chk($sformatf("tbl%0d_valid", i), 32'(va), 32'(tbl[i].v));
         chk($sformatf("tbl%0d_data", i), da, {tbl[i].d1, tbl[i].d0});
         chk($sformatf("tbl%0d_full", i), 32'(fa), 32'(tbl[i].f));
         chk($sformatf("tbl%0d_empty", i), 32'(ea), 32'(tbl[i].e));
         chk($sformatf("tbl%0d_drop", i), 32'(dra), 32'(tbl[i].drop));
         chk($sformatf("tbl%0d_under", i), 32'(ua), 32'(tbl[i].und));
      end

      // full lane: replay bank drops, plain bank accepts when a read frees a slot the same cycle
      idle();
      for (int k = 0; k < 4; k++) begin
         wv = 2'b01; wd = {16'd0, 16'(41 + k)};
         step();
      end
      chk("full_b_before", 32'(fb[0]), 1);
      wv = 2'b01; wd = {16'd0, 16'd7}; rd = 1'b1;
      step();
      chk("full_wr_b_valid", 32'(vb[0]), 1);
      chk("full_wr_b_data", 32'(db[15:0]), 41);
      chk("full_wr_b_full", 32'(fb[0]), 1);
      chk("full_wr_b_drop", 32'(drb), 0);
      chk("full_wr_a_drop", 32'(dra), 1);
      chk("full_wr_a_full", 32'(fa[0]), 1);
      idle(); rd = 1'b1;
      repeat (5) step();
      chk("plain_tail_data", 32'(db[15:0]), 7);
      idle(); fl = 1'b1;
      step();

      // async reset while lane 1 read is still in the skew chain
      idle(); wv = 2'b11; wd = {16'd55, 16'd66};
      step();
      idle(); rd = 1'b1;
      step();
      idle();
      #2 rst = 1'b1;
      #1;
      chk("arst_valid_a", 32'(va), 0);
      chk("arst_data_a", da, 0);
      chk("arst_valid_b", 32'(vb), 0);
      chk("arst_empty_a", 32'(ea), 3);
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (3) begin
         step();
         chk("post_rst_no_valid", 32'(va | vb), 0);
      end

      // random traffic against the model
      for (int c = 0; c < 3000; c++) begin
         wv = 2'($urandom);
         nv = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
         wd = $urandom; nd = $urandom;
         rd = 1'($urandom);
         mk = $urandom_range(0, 9) == 0;
         rw = $urandom_range(0, 19) == 0;
         fl = $urandom_range(0, 49) == 0;
         step();
      end
      idle();

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
